// File: rtl/ifid_elastic_reg.sv
//-----------------------------------------------------------------------------
// ifid_elastic_reg
//
// IF/ID pipeline register for the MIPS core, built as a small in-order
// elastic queue between fetch and decode. Fetch and decode each use a
// valid/ready handshake. An entry carries {pc, instr, exc, bd}. A fetch-side
// exception squashes the instruction to NOP. The PC, exception code and
// delay-slot flag still travel down so EPC/BD can be formed later.
//
// When the queue is empty, decode sees a bubble. The bubble is a NOP with no
// exception and bd = 0. It reports the PC of the last instruction that was
// shown (hold_pc). PC+4 and PC+8 are derived from whatever pc_d is showing.
//
// Parameters
//   PC_W      PC width
//   INSTR_W   instruction width
//   EXC_W     exception-code width
//   EXC_NONE  "no exception" code
//   NOP       bubble / squashed instruction
//   RESET_PC  PC shown while empty after reset
//   DEPTH     queue entries (power of two, >= 2)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   flush      in   discard all entries (exception entry / eret)
//   in_valid   in   fetch presents an entry
//   in_ready   out  queue can accept (depends on registered state only)
//   pc_f       in   fetch PC
//   instr_f    in   fetched instruction
//   exc_f      in   fetch exception code
//   bd_f       in   entry sits in a branch delay slot
//   out_valid  out  head entry valid
//   out_ready  in   decode consumes the head (0 = decode stall)
//   pc_d       out  head PC (hold_pc when empty)
//   pc4_d      out  pc_d + 4
//   pc8_d      out  pc_d + 8
//   instr_d    out  head instruction (NOP when empty)
//   exc_d      out  head exception code (EXC_NONE when empty)
//   bd_d       out  head delay-slot flag (0 when empty)
//   level      out  occupied entries, 0..DEPTH
//-----------------------------------------------------------------------------
module ifid_elastic_reg #(
    parameter int                 PC_W     = 32,
    parameter int                 INSTR_W  = 32,
    parameter int                 EXC_W    = 5,
    parameter logic [EXC_W-1:0]   EXC_NONE = 5'd0,
    parameter logic [INSTR_W-1:0] NOP      = 32'h0000_0000,
    parameter logic [PC_W-1:0]    RESET_PC = 32'h0000_3000,
    parameter int                 DEPTH    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            pc_f,
    input  logic [INSTR_W-1:0]         instr_f,
    input  logic [EXC_W-1:0]           exc_f,
    input  logic                       bd_f,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            pc_d,
    output logic [PC_W-1:0]            pc4_d,
    output logic [PC_W-1:0]            pc8_d,
    output logic [INSTR_W-1:0]         instr_d,
    output logic [EXC_W-1:0]           exc_d,
    output logic                       bd_d,

    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Width-matched constants, so that compares and increments stay lint-clean.
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PC_W-1:0]  PC_FOUR  = PC_W'(4);
    localparam logic [PC_W-1:0]  PC_EIGHT = PC_W'(8);

    //-------------------------------------------------------------------------
    // State
    //-------------------------------------------------------------------------
    logic [PC_W-1:0]    r_mem_pc    [DEPTH];
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [EXC_W-1:0]   r_mem_exc   [DEPTH];
    logic               r_mem_bd    [DEPTH];

    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [PC_W-1:0]    r_hold_pc;

    //-------------------------------------------------------------------------
    // Handshake decode
    //-------------------------------------------------------------------------
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;
    logic [INSTR_W-1:0] w_instr_wr;
    logic [PC_W-1:0]    w_head_pc;

    // in_ready depends only on the registered count. A full queue therefore
    // refuses a push even on an edge that also pops, which keeps out_ready
    // off the fetch-side ready path.
    assign w_in_ready  = (r_count < DEPTH_C);
    assign w_out_valid = (r_count != '0);

    assign w_push = in_valid  & w_in_ready  & ~flush;
    assign w_pop  = w_out_valid & out_ready & ~flush;

    // A faulting fetch must not reach decode as a real instruction.
    assign w_instr_wr = (exc_f == EXC_NONE) ? instr_f : NOP;

    assign w_head_pc = r_mem_pc[r_rd_ptr];

    //-------------------------------------------------------------------------
    // Storage array
    //-------------------------------------------------------------------------
    // NOTE: the array is deliberately left without reset. Empty slots are
    // never observed, because out_valid gates every read. Keeping reset off
    // these flops lets them map to plain registers or LUT-RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= pc_f;
            r_mem_instr[r_wr_ptr] <= w_instr_wr;
            r_mem_exc[r_wr_ptr]   <= exc_f;
            r_mem_bd[r_wr_ptr]    <= bd_f;
        end
    end

    //-------------------------------------------------------------------------
    // Pointers and occupancy
    //-------------------------------------------------------------------------
    // NOTE: every sequential assignment uses <=. All flops then sample the
    // pre-edge values, and the order of statements inside a block cannot
    // change the result.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // hold_pc follows the head on every edge with a visible entry. Flush is
    // deliberately ignored here, so a bubble after a flush still reports the
    // PC that decode saw last.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_pc <= RESET_PC;
        end else if (w_out_valid) begin
            r_hold_pc <= w_head_pc;
        end
    end

    //-------------------------------------------------------------------------
    // Decode-side view: head entry or bubble
    //-------------------------------------------------------------------------
    logic [PC_W-1:0]    w_pc_d;
    logic [INSTR_W-1:0] w_instr_d;
    logic [EXC_W-1:0]   w_exc_d;
    logic               w_bd_d;

    // NOTE: the bubble values are assigned first, so every path through the
    // block drives every output and no latch can be inferred.
    always_comb begin
        w_pc_d    = r_hold_pc;
        w_instr_d = NOP;
        w_exc_d   = EXC_NONE;
        w_bd_d    = 1'b0;
        if (w_out_valid) begin
            w_pc_d    = w_head_pc;
            w_instr_d = r_mem_instr[r_rd_ptr];
            w_exc_d   = r_mem_exc[r_rd_ptr];
            w_bd_d    = r_mem_bd[r_rd_ptr];
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign pc_d      = w_pc_d;
    assign pc4_d     = w_pc_d + PC_FOUR;   // modulo 2^PC_W
    assign pc8_d     = w_pc_d + PC_EIGHT;  // modulo 2^PC_W
    assign instr_d   = w_instr_d;
    assign exc_d     = w_exc_d;
    assign bd_d      = w_bd_d;
    assign level     = r_count;

endmodule
